pcie_us_cfg_mgmt_resp: RTL and testbench
========================================

# pcie_us_cfg_mgmt_resp

Responder model for the UltraScale PCIe hard block configuration management port. It sits on the core side of the `cfg_mgmt_*` interface that the DMA bench logic drives as initiator. It answers dword reads and writes against a small backed register file after a programmable latency. It also exports `cfg_max_payload` and `cfg_max_read_req`, decoded from its emulated Device Control register. It lets simulation and loopback builds run the DMA bench without the hard block.

## Interface
Parameters:
- `REG_COUNT`, 64: number of backed dwords, at addresses 0..REG_COUNT-1; a power of two, at most 1024.
- `LATENCY`, 4: cycles from request capture to done pulse; at least 2.
- `DEVCTL_ADDR`, 10'h01E: dword address of the Device Control/Status register.
- `DEVCTL_INIT`, 32'h0000_2020: reset value of DEVCTL (MPS=256 B, MRRS=512 B).
- `ID_VALUE`, 32'h9038_10EE: read-only value at dword address 0.

Ports:
- `clk` in 1: single clock; all logic is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `cfg_mgmt_addr` in 10: dword address.
- `cfg_mgmt_function_number` in 8: PCIe function; only function 0 is backed.
- `cfg_mgmt_write` in 1: write request, level, held until done.
- `cfg_mgmt_write_data` in 32: write data.
- `cfg_mgmt_byte_enable` in 4: per-byte write enable.
- `cfg_mgmt_read` in 1: read request, level, held until done.
- `cfg_mgmt_read_data` out 32: read result; valid in the done cycle, held until the next read completes.
- `cfg_mgmt_read_write_done` out 1: one-cycle completion pulse.
- `cfg_max_payload` out 3: DEVCTL[7:5].
- `cfg_max_read_req` out 3: DEVCTL[14:12].

## Operation
- State machine:
  - IDLE → BUSY when `cfg_mgmt_read` or `cfg_mgmt_write` is high. Address, function, data, byte enables and type are captured and the latency counter is loaded.
  - BUSY → DONE when the counter expires.
  - DONE → IDLE unconditionally.
- Requests are ignored in BUSY and DONE. Request inputs may change while BUSY without effect.
- Simultaneous read and write: the write takes precedence and no read data is updated.
- Write, function 0, addr < REG_COUNT, addr ≠ 0:
  - Each byte i with byte_enable[i]=1 replaces register byte i; other bytes are kept.
  - The commit happens at the edge ending the DONE cycle.
- Writes to addr 0, to addr ≥ REG_COUNT, or with function ≠ 0 are dropped. They still complete with a done pulse.
- Read returns:
  - ID_VALUE at addr 0.
  - The register value at other in-range addrs.
  - 32'h0 for out-of-range addrs or function ≠ 0.
- `read_data` is loaded on the DONE cycle for reads only; it is unchanged by writes.
- Read of an address written with byte_enable=4'b0000 returns the unchanged prior value.
- `cfg_max_payload` and `cfg_max_read_req` are combinational from the DEVCTL register. They reflect a DEVCTL write from the cycle after DONE.

## Timing
- A request first seen high in IDLE in cycle T gives `read_write_done`=1 in cycle T+LATENCY only (macro off).
- Back-to-back: the initiator deasserts in T+LATENCY+1. A new request present in T+LATENCY+1 is captured in that cycle, because the block is back in IDLE.
- Sustained throughput is one access per LATENCY+1 cycles.
- Latency counter width is clog2(LATENCY+4). It counts down and never wraps.
- Reset values:
  - State IDLE, `read_write_done`=0, `read_data`=0.
  - All registers 0 except DEVCTL=DEVCTL_INIT.
  - `cfg_max_payload`=DEVCTL_INIT[7:5], `cfg_max_read_req`=DEVCTL_INIT[14:12].
- Reset asserted mid-transaction aborts it: no done pulse and no register commit. A request still held after reset deasserts is captured anew in the first non-reset cycle.

## Configuration
- `CFG_MGMT_RESP_RANDOM_LATENCY_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,15,13,4; seed 16'hACE1 on reset) advances every cycle.
  - At capture, the effective latency is LATENCY + LFSR[1:0], a range of LATENCY..LATENCY+3.
  - The done pulse is still exactly one cycle.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

## Test plan
- Reset, then read addr 10'h01E, function 0: done at capture+4, read_data=32'h0000_2020; cfg_max_payload=3'd1, cfg_max_read_req=3'd2.
- Write 32'h0000_5040 to addr 10'h01E with be=4'b0011: cfg_max_payload=3'd2 and cfg_max_read_req=3'd5 from the cycle after done. A readback returns 32'h0000_5040.
- Write 32'hAABB_CCDD to addr 5 with be=4'b0101, after a prior full write of 32'h1122_3344: readback returns 32'h11BB_33DD.
- Write 32'hFFFF_FFFF to addr 0, then read addr 0, addr 64 and function 1 addr 5: results 32'h9038_10EE, 0 and 0. Each access completes with exactly one done pulse.
- Assert rst two cycles after capturing a write to addr 7: no done pulse; a subsequent read of addr 7 returns 0.
- Assert read and write together, write 32'h1234_5678 to addr 3: done pulse, read_data unchanged, addr 3 reads back 32'h1234_5678. With the macro defined, 1000 random accesses all complete within 4..7 cycles.

Source files
------------

// File: rtl/pcie_us_cfg_mgmt_resp.sv
// -----------------------------------------------------------------------------
// pcie_us_cfg_mgmt_resp
//
// Responder model for the UltraScale PCIe configuration management port. It
// answers dword reads and writes from the cfg_mgmt_* initiator against a small
// register file, after a programmable latency. It also exports the Max Payload
// Size and Max Read Request Size fields of an emulated Device Control register.
//
// Ports
//   clk                       single clock
//   rst                       synchronous, active-high reset
//   cfg_mgmt_addr      [9:0]  dword address
//   cfg_mgmt_function_number  PCIe function (only function 0 is backed)
//   cfg_mgmt_write            write request level, held until done
//   cfg_mgmt_write_data       write data
//   cfg_mgmt_byte_enable      per-byte write enable
//   cfg_mgmt_read             read request level, held until done
//   cfg_mgmt_read_data        read result, valid in the done cycle and held
//   cfg_mgmt_read_write_done  one-cycle completion pulse
//   cfg_max_payload           DEVCTL[7:5]
//   cfg_max_read_req          DEVCTL[14:12]
//
// Build option
//   CFG_MGMT_RESP_RANDOM_LATENCY_EN : when defined, a free-running 16-bit LFSR
//   adds 0..3 extra cycles to each access. When undefined, every access takes
//   exactly LATENCY cycles.
// -----------------------------------------------------------------------------
module pcie_us_cfg_mgmt_resp #(
  parameter int          REG_COUNT   = 64,
  parameter int          LATENCY     = 4,
  parameter logic [9:0]  DEVCTL_ADDR = 10'h01E,
  parameter logic [31:0] DEVCTL_INIT = 32'h0000_2020,
  parameter logic [31:0] ID_VALUE    = 32'h9038_10EE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic [2:0]  cfg_max_payload,
  output logic [2:0]  cfg_max_read_req
);

  localparam int AW = $clog2(REG_COUNT);
  localparam int CW = $clog2(LATENCY + 4);
  localparam logic [AW-1:0] DEVCTL_IDX = DEVCTL_ADDR[AW-1:0];

  // The BUSY phase lasts LATENCY-1 cycles, so the counter is loaded with the
  // number of BUSY cycles remaining after the first one.
  localparam logic [CW-1:0] CNT_BASE = CW'(LATENCY - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [9:0]    addr_q,  addr_d;
  logic [7:0]    func_q,  func_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q,    be_d;
  logic          is_wr_q, is_wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q,  done_d;
  logic [31:0]   regs_q [REG_COUNT];
  logic [31:0]   regs_d [REG_COUNT];

  logic          target_ok;
  logic [31:0]   rd_value;
  logic [31:0]   wr_merged;
  logic [CW-1:0] cnt_load;

`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,15,13,4; advances every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  end

  assign cnt_load = CNT_BASE + CW'(lfsr_q[1:0]);
`else
  assign cnt_load = CNT_BASE;
`endif

  // Function 0 and an address inside the backed range.
  assign target_ok = (func_q == 8'd0) && ({1'b0, addr_q} < 11'(REG_COUNT));

  always_comb begin
    rd_value = 32'h0;
    if (target_ok) begin
      rd_value = (addr_q == 10'd0) ? ID_VALUE : regs_q[addr_q[AW-1:0]];
    end
  end

  always_comb begin
    wr_merged = regs_q[addr_q[AW-1:0]];
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) wr_merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    func_d  = func_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    regs_d  = regs_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_mgmt_read || cfg_mgmt_write) begin
          state_d = S_BUSY;
          cnt_d   = cnt_load;
          addr_d  = cfg_mgmt_addr;
          func_d  = cfg_mgmt_function_number;
          wdata_d = cfg_mgmt_write_data;
          be_d    = cfg_mgmt_byte_enable;
          // A write wins over a simultaneous read.
          is_wr_d = cfg_mgmt_write;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          // Read data is loaded as DONE is entered so it is valid with done.
          if (!is_wr_q) rdata_d = rd_value;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // Address 0 is the read-only ID; writes there are dropped.
        if (is_wr_q && target_ok && (addr_q != 10'd0)) begin
          regs_d[addr_q[AW-1:0]] = wr_merged;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      func_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      // NOTE: the register file is reset explicitly because it is software
      // visible state with defined reset values, not scratch RAM.
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= (i == int'(DEVCTL_ADDR)) ? DEVCTL_INIT : 32'h0;
      end
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
      lfsr_q  <= 16'hACE1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      func_q  <= func_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign cfg_mgmt_read_data       = rdata_q;
  assign cfg_mgmt_read_write_done = done_q;
  assign cfg_max_payload          = regs_q[DEVCTL_IDX][7:5];
  assign cfg_max_read_req         = regs_q[DEVCTL_IDX][14:12];

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_resp.sv
// -----------------------------------------------------------------------------
// Testbench for pcie_us_cfg_mgmt_resp. Stimulus is driven on the falling edge;
// expected read data is pushed to a scoreboard queue when an access is issued
// and popped when the done pulse is observed.
// -----------------------------------------------------------------------------
module tb_pcie_us_cfg_mgmt_resp;

  localparam int          LATENCY  = 4;
  localparam int          NREG     = 64;
  localparam logic [31:0] ID_VAL   = 32'h9038_10EE;
  localparam int          DEVCTL   = 30;
  localparam int          MAX_WAIT = LATENCY + 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic [7:0]  func;
  logic        wr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        rd;
  logic [31:0] rdata;
  logic        done;
  logic [2:0]  mps;
  logic [2:0]  mrrs;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_regs [NREG];
  logic [31:0] model_last_rd;

  always #5 clk = ~clk;

  pcie_us_cfg_mgmt_resp #(
    .REG_COUNT  (NREG),
    .LATENCY    (LATENCY),
    .DEVCTL_ADDR(10'h01E),
    .DEVCTL_INIT(32'h0000_2020),
    .ID_VALUE   (ID_VAL)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .cfg_mgmt_addr           (addr),
    .cfg_mgmt_function_number(func),
    .cfg_mgmt_write          (wr),
    .cfg_mgmt_write_data     (wdata),
    .cfg_mgmt_byte_enable    (be),
    .cfg_mgmt_read           (rd),
    .cfg_mgmt_read_data      (rdata),
    .cfg_mgmt_read_write_done(done),
    .cfg_max_payload         (mps),
    .cfg_max_read_req        (mrrs)
  );

  // ---------------------------------------------------------------- model
  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model_regs[i] = 32'h0;
    model_regs[DEVCTL] = 32'h0000_2020;
    model_last_rd = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] f, input logic [9:0] a);
    if (f != 8'd0 || a >= 10'(NREG)) return 32'h0;
    if (a == 10'd0) return ID_VAL;
    return model_regs[a];
  endfunction

  task automatic model_write(input logic [7:0] f, input logic [9:0] a,
                             input logic [31:0] d, input logic [3:0] b);
    if (f == 8'd0 && a != 10'd0 && a < 10'(NREG)) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) model_regs[a][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // Issue one access at a falling edge, wait for done, check latency and read
  // data, then check that done falls in the following (IDLE) cycle. Returns at
  // the falling edge of the cycle after DONE, ready for a back-to-back access.
  task automatic do_access(input string name, input logic [7:0] f, input logic [9:0] a,
                           input logic w, input logic r, input logic [31:0] d,
                           input logic [3:0] b);
    int n;
    logic [31:0] exp;
    bit got;
    func = f; addr = a; wr = w; rd = r; wdata = d; be = b;
    if (w) begin
      exp_q.push_back(model_last_rd);
      model_write(f, a, d, b);
    end else begin
      model_last_rd = model_read(f, a);
      exp_q.push_back(model_last_rd);
    end
    got = 1'b0;
    for (n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Captured fields must not follow the live inputs while busy.
        addr = 10'($urandom); func = 8'($urandom); wdata = $urandom; be = 4'($urandom);
      end
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no done within %0d cycles", name, MAX_WAIT);
    end else begin
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
      if (n < LATENCY || n > LATENCY + 3) begin
`else
      if (n != LATENCY) begin
`endif
        failures++;
        $display("FAIL %s latency: got %0d expected %0d", name, n, LATENCY);
      end
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("FAIL %s read_data: got %h expected %h", name, rdata, exp);
      end
    end
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width: done still %b after one cycle", name, done);
    end
  endtask

  task automatic check_devctl_out(input string name, input logic [2:0] emps,
                                  input logic [2:0] emrrs);
    checks++;
    if (mps !== emps || mrrs !== emrrs) begin
      failures++;
      $display("FAIL %s: mps=%0d mrrs=%0d expected mps=%0d mrrs=%0d",
               name, mps, mrrs, emps, emrrs);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; func = '0; wdata = '0; be = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: done=%b read_data=%h expected 0 and 0", done, rdata);
    end
    check_devctl_out("reset_devctl", 3'd1, 3'd2);
  endtask

  task automatic test_devctl();
    do_access("devctl_rd", 8'd0, 10'h01E, 1'b0, 1'b1, 32'h0, 4'h0);
    check_devctl_out("devctl_init", 3'd1, 3'd2);
    do_access("devctl_wr", 8'd0, 10'h01E, 1'b1, 1'b0, 32'h0000_5040, 4'b0011);
    check_devctl_out("devctl_update", 3'd2, 3'd5);
    do_access("devctl_rb", 8'd0, 10'h01E, 1'b0, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic test_byte_enable();
    do_access("be_full_wr", 8'd0, 10'd5, 1'b1, 1'b0, 32'h1122_3344, 4'hF);
    do_access("be_part_wr", 8'd0, 10'd5, 1'b1, 1'b0, 32'hAABB_CCDD, 4'b0101);
    do_access("be_part_rb", 8'd0, 10'd5, 1'b0, 1'b1, 32'h0, 4'h0);
    do_access("be_none_wr", 8'd0, 10'd5, 1'b1, 1'b0, 32'h5555_5555, 4'b0000);
    do_access("be_none_rb", 8'd0, 10'd5, 1'b0, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic test_dropped();
    do_access("id_wr",      8'd0, 10'd0,  1'b1, 1'b0, 32'hFFFF_FFFF, 4'hF);
    do_access("id_rd",      8'd0, 10'd0,  1'b0, 1'b1, 32'h0, 4'h0);
    do_access("oor_wr",     8'd0, 10'd64, 1'b1, 1'b0, 32'hFFFF_FFFF, 4'hF);
    do_access("oor_rd",     8'd0, 10'd64, 1'b0, 1'b1, 32'h0, 4'h0);
    do_access("fn1_wr",     8'd1, 10'd5,  1'b1, 1'b0, 32'h0BAD_0BAD, 4'hF);
    do_access("fn1_rd",     8'd1, 10'd5,  1'b0, 1'b1, 32'h0, 4'h0);
    do_access("fn0_rb",     8'd0, 10'd5,  1'b0, 1'b1, 32'h0, 4'h0);
    do_access("top_wr",     8'd0, 10'd63, 1'b1, 1'b0, 32'hCAFE_F00D, 4'hF);
    do_access("top_rd",     8'd0, 10'd63, 1'b0, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic test_reset_abort();
    bit seen;
    func = 8'd0; addr = 10'd7; wr = 1'b1; rd = 1'b0; wdata = 32'hDEAD_BEEF; be = 4'hF;
    @(negedge clk);           // capture happened at the preceding rising edge
    @(negedge clk);
    rst = 1'b1;               // sampled two cycles after capture
    seen = done;
    @(negedge clk);
    wr = 1'b0;
    seen |= done;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      seen |= done;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_done: done pulse seen after aborting reset");
    end
    check_devctl_out("abort_devctl", 3'd1, 3'd2);
    do_access("abort_rd", 8'd0, 10'd7, 1'b0, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic test_rw_collision();
    do_access("coll_pre", 8'd0, 10'd0, 1'b0, 1'b1, 32'h0, 4'h0);
    do_access("coll_rw",  8'd0, 10'd3, 1'b1, 1'b1, 32'h1234_5678, 4'hF);
    do_access("coll_rb",  8'd0, 10'd3, 1'b0, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    int count;
    logic [7:0] f;
    logic w;
`ifdef CFG_MGMT_RESP_RANDOM_LATENCY_EN
    count = 1000;
`else
    count = 40;
`endif
    for (int i = 0; i < count; i++) begin
      f = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
      w = 1'($urandom);
      do_access("b2b", f, 10'($urandom_range(0, 70)), w, (!w) || 1'($urandom),
                $urandom, 4'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_devctl();
    test_byte_enable();
    test_dropped();
    test_reset_abort();
    test_rw_collision();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
